inject_sched: RTL and testbench

INJECT_SCHED -- requirements
Module: inject_sched

---
 rtl/inject_sched.sv | 81 ++++++++
 tb/tb_inject_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inject_sched.sv
// Injection scheduler: round-robin arbitration of N local requesters onto one
// PE injection port, rate-limited by a token bucket, with a one-deep output register.
module inject_sched #(
  parameter int P_W       = 16,
  parameter int N         = 4,
  parameter int MAX_RATE  = 4,
  parameter int MAX_TOKEN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*P_W-1:0]     req_pkt,
  input  logic [N-1:0]         req_vld,
  output logic [N-1:0]         req_rdy,
  input  logic                 sw_rdy,
  output logic [P_W-1:0]       out_pkt,
  output logic                 out_vld
);
  localparam int PW = $clog2(N);
  localparam int CW = (MAX_RATE > 1) ? $clog2(MAX_RATE) : 1;
  localparam int TW = $clog2(MAX_TOKEN + 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]              state;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           tokens, tokens_nxt;
  logic [TW:0]             tok_sum;
  logic [PW-1:0]           ptr, grant;
  logic [N-1:0][P_W-1:0]   pkt_a;
  logic                    wrap, load, found;
  logic [PW-1:0]           idx;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign pkt_a[i] = req_pkt[i*P_W +: P_W];
  end

  assign wrap    = (cnt == CW'(MAX_RATE - 1));
  assign load    = !rst && (state == EMPTY || sw_rdy) && (tokens != '0) && (|req_vld);
  assign out_vld = (state == FULL);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req_vld[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign req_rdy = load ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;

  // Refill and consume in the same cycle cancel; only the net result saturates.
  assign tok_sum    = {1'b0, tokens} + (TW+1)'(wrap) - (TW+1)'(load);
  assign tokens_nxt = (tok_sum > (TW+1)'(MAX_TOKEN)) ? TW'(MAX_TOKEN) : tok_sum[TW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      out_pkt <= '0;
      tokens  <= TW'(MAX_TOKEN);
      cnt     <= '0;
      ptr     <= PW'(N - 1);
    end else begin
      cnt    <= wrap ? '0 : cnt + CW'(1);
      tokens <= tokens_nxt;
      if (load) begin
        out_pkt <= pkt_a[grant];
        ptr     <= grant;
        state   <= FULL;
      end else if (sw_rdy) begin
        state   <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_inject_sched.sv
// Bench for inject_sched: directed scenarios plus a long random run, checked by a
// token-bucket/round-robin reference model and a packet scoreboard.
module tb_inject_sched;
  localparam int P_W = 16;
  localparam int N   = 4;
  localparam int R   = 4;
  localparam int M   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*P_W-1:0] req_pkt = '0;
  logic [N-1:0]     req_vld = '0;
  logic [N-1:0]     req_rdy;
  logic             sw_rdy  = 1'b0;
  logic [P_W-1:0]   out_pkt;
  logic             out_vld;

  logic [N*P_W-1:0] pkt1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [N-1:0]     vld1 = 4'hF;
  logic             sw1  = 1'b1;
  logic [N-1:0]     req_rdy1;
  logic [P_W-1:0]   out_pkt1;
  logic             out_vld1;

  inject_sched #(.P_W(P_W), .N(N), .MAX_RATE(R), .MAX_TOKEN(M)) dut (
    .clk(clk), .rst(rst), .req_pkt(req_pkt), .req_vld(req_vld), .req_rdy(req_rdy),
    .sw_rdy(sw_rdy), .out_pkt(out_pkt), .out_vld(out_vld));

  inject_sched #(.P_W(P_W), .N(N), .MAX_RATE(1), .MAX_TOKEN(1)) dut1 (
    .clk(clk), .rst(rst), .req_pkt(pkt1), .req_vld(vld1), .req_rdy(req_rdy1),
    .sw_rdy(sw1), .out_pkt(out_pkt1), .out_vld(out_vld1));

  int total = 0;
  int bad   = 0;

  // Reference model state: tokens, refill phase, last grant, output occupancy.
  int             m_tok, m_cnt, m_ptr, t;
  bit             m_full;
  logic [P_W-1:0] expq[$];
  int             gcyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0d", name, act, exp, t);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  function automatic logic [N*P_W-1:0] rnd_pkt();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_tok = M; m_cnt = 0; m_ptr = N - 1; m_full = 0; t = 0;
    expq.delete();
    gcyc.delete();
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic [N-1:0] v, input logic s, input logic [N*P_W-1:0] p,
                      output int g);
    bit ok;
    bit wr;
    int nt;
    @(negedge clk);
    req_vld = v; sw_rdy = s; req_pkt = p;
    #1;
    chk("out_vld", out_vld, m_full);
    g = -1;
    if ((!m_full || s) && m_tok > 0 && v != 0)
      for (int k = 1; k <= N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    chk("req_rdy", req_rdy, onehot(g));
    if (g >= 0) begin
      expq.push_back(p[g*P_W +: P_W]);
      gcyc.push_back(t);
      // grants in cycles [a,t] can use the starting bucket plus refills completed before t
      ok = 1;
      for (int j = gcyc.size() - 1; j >= 0 && j >= gcyc.size() - 10; j--)
        if (gcyc.size() - j > M + t / R - gcyc[j] / R) ok = 0;
      chk("rate_window", ok, 1);
    end
    wr = (m_cnt == R - 1);
    nt = m_tok - (g >= 0 ? 1 : 0) + (wr ? 1 : 0);
    m_tok  = (nt > M) ? M : nt;
    m_cnt  = wr ? 0 : m_cnt + 1;
    m_full = (g >= 0) ? 1 : (s ? 0 : m_full);
    if (g >= 0) m_ptr = g;
    t++;
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    @(negedge clk);
    req_vld = v; sw_rdy = 1'b1; rst = 1'b1;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_pkt", out_pkt, 0);
    chk("rst_req_rdy", req_rdy, 0);
    repeat (2) @(negedge clk);
    chk("rst_req_rdy_hold", req_rdy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: every transfer to the switch must match the next accepted packet.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_vld && sw_rdy) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_extra actual=%0h required=none t=%0d", out_pkt, t);
        end else begin
          chk("sb_pkt", out_pkt, expq.pop_front());
        end
      end
    end
  end

  initial begin
    int g;
    int exp_a[14] = '{0, 1, -1, -1, 2, -1, -1, -1, 3, -1, -1, -1, 0, -1};
    int exp_b[9]  = '{0, 2, -1, -1, 0, -1, -1, -1, 2};
    int exp_c[6]  = '{1, 2, 3, -1, -1, -1};
    logic [N*P_W-1:0] p;

    model_reset();
    do_reset('0);

    // all requesters, switch always ready: burst of M then one per refill period
    for (int k = 0; k < 14; k++) begin
      step(4'hF, 1'b1, rnd_pkt(), g);
      chk("burst_rdy", req_rdy, onehot(exp_a[k]));
      chk("r1_rdy", req_rdy1, onehot(k % N));
      if (k > 0) begin
        chk("r1_vld", out_vld1, 1);
        chk("r1_pkt", out_pkt1, pkt1[((k - 1) % N)*P_W +: P_W]);
      end
    end

    // sparse requesters skip idle indices
    do_reset('0);
    for (int k = 0; k < 9; k++) begin
      step(4'b0101, 1'b1, rnd_pkt(), g);
      chk("alt_rdy", req_rdy, onehot(exp_b[k]));
      chk("alt_rdy13", {req_rdy[3], req_rdy[1]}, 0);
    end

    // backpressure holds the packet; bucket must not overfill while stalled
    do_reset('0);
    p = rnd_pkt();
    p[P_W-1:0] = 16'hA5A5;
    step(4'b0001, 1'b0, p, g);
    for (int k = 1; k < 10; k++) begin
      step(4'hF, 1'b0, rnd_pkt(), g);
      chk("hold_vld", out_vld, 1);
      chk("hold_pkt", out_pkt, 16'hA5A5);
      chk("hold_rdy", req_rdy, 0);
    end
    for (int k = 0; k < 6; k++) begin
      step(4'hF, 1'b1, rnd_pkt(), g);
      chk("post_hold_rdy", req_rdy, onehot(exp_c[k]));
    end

    // reset while holding a packet
    step(4'hF, 1'b0, rnd_pkt(), g);
    step(4'hF, 1'b0, rnd_pkt(), g);
    chk("pre_rst_vld", out_vld, 1);
    do_reset(4'hF);
    step(4'hF, 1'b1, rnd_pkt(), g);
    chk("post_rst_grant", req_rdy, 4'b0001);

    // long random run
    for (int k = 0; k < 10000; k++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), rnd_pkt(), g);
    repeat (4) step('0, 1'b1, rnd_pkt(), g);
    #3;
    chk("sb_drain", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
